// File: rtl/path_lookup_arbiter.sv
// rtl/path_lookup_arbiter.sv - round-robin sharing of the pathID lookup port with tagged response routing
// Requester tags ride a LAT+1 deep pipeline so each returning pathID is steered back to its issuer.
module path_lookup_arbiter #(
  parameter int N_REQ    = 4,
  parameter int W_RULEID = 16,
  parameter int W_PATHID = 18,
  parameter int LAT      = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      arb_en_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*W_RULEID-1:0] req_ruleID_i,
  input  logic [N_REQ-1:0]          req_hit_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic                      ruleID_valid_o,
  output logic [W_RULEID-1:0]       ruleID_o,
  output logic                      hit_o,
  input  logic                      pathID_valid_i,
  input  logic [W_PATHID-1:0]       pathID_i,
  output logic [N_REQ-1:0]          resp_valid_o,
  output logic [W_PATHID-1:0]       resp_pathID_o,
  output logic [1:0]                err_o,
  output logic [31:0]               grant_cnt_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int GW = $clog2(LAT + 2);
  localparam logic [IW-1:0] PTR_RST   = IW'(N_REQ - 1);
  localparam logic [GW-1:0] GUARD_RST = GW'(LAT + 1);

  logic [IW-1:0]       ptr_q, ptr_d;
  logic                rv_q, rv_d;
  logic [W_RULEID-1:0] rid_q, rid_d;
  logic                hit_q, hit_d;
  logic [LAT:0]        tag_vld_q, tag_vld_d;
  logic [IW-1:0]       tag_idx_q [LAT+1];
  logic [N_REQ-1:0]    resp_valid_q, resp_valid_d;
  logic [W_PATHID-1:0] resp_path_q, resp_path_d;
  logic [1:0]          err_q, err_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [GW-1:0]       guard_q, guard_d;

  logic                gnt_found;
  logic [IW-1:0]       gnt_idx;
  logic [IW-1:0]       cand;
  logic                tap_vld;
  logic [IW-1:0]       tap_idx;

  // Search starts one past the last winner; reset leaves ptr at N_REQ-1 so requester 0 leads.
  always_comb begin
    gnt_found   = 1'b0;
    gnt_idx     = '0;
    cand        = '0;
    req_ready_o = '0;
    if (arb_en_i && !reset_i) begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = IW'((int'(ptr_q) + k) % N_REQ);
        if (!gnt_found && req_valid_i[cand]) begin
          gnt_found = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
    if (gnt_found) req_ready_o[gnt_idx] = 1'b1;
  end

  assign tap_vld = tag_vld_q[LAT];
  assign tap_idx = tag_idx_q[LAT];

  always_comb begin
    ptr_d        = ptr_q;
    rv_d         = gnt_found;
    rid_d        = rid_q;
    hit_d        = hit_q;
    cnt_d        = cnt_q;
    tag_vld_d    = {tag_vld_q[LAT-1:0], gnt_found};
    resp_valid_d = '0;
    resp_path_d  = resp_path_q;
    err_d        = err_q;
    guard_d      = (guard_q != '0) ? guard_q - 1'b1 : guard_q;

    if (gnt_found) begin
      ptr_d = gnt_idx;
      rid_d = req_ruleID_i[gnt_idx*W_RULEID +: W_RULEID];
      hit_d = req_hit_i[gnt_idx];
      cnt_d = cnt_q + 32'd1;
    end

    if (tap_vld && pathID_valid_i) begin
      resp_valid_d[tap_idx] = 1'b1;
      resp_path_d           = pathID_i;
    end

    // Masked right after reset so answers to lookups issued before reset stay silent.
    if (guard_q == '0) begin
      if (pathID_valid_i && !tap_vld) err_d[0] = 1'b1;
      if (tap_vld && !pathID_valid_i) err_d[1] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q        <= PTR_RST;
      rv_q         <= 1'b0;
      rid_q        <= '0;
      hit_q        <= 1'b0;
      cnt_q        <= '0;
      tag_vld_q    <= '0;
      resp_valid_q <= '0;
      resp_path_q  <= '0;
      err_q        <= '0;
      guard_q      <= GUARD_RST;
      for (int k = 0; k <= LAT; k++) tag_idx_q[k] <= '0;
    end else begin
      ptr_q        <= ptr_d;
      rv_q         <= rv_d;
      rid_q        <= rid_d;
      hit_q        <= hit_d;
      cnt_q        <= cnt_d;
      tag_vld_q    <= tag_vld_d;
      resp_valid_q <= resp_valid_d;
      resp_path_q  <= resp_path_d;
      err_q        <= err_d;
      guard_q      <= guard_d;
      tag_idx_q[0] <= gnt_idx;
      for (int k = 1; k <= LAT; k++) tag_idx_q[k] <= tag_idx_q[k-1];
    end
  end

  assign ruleID_valid_o = rv_q;
  assign ruleID_o       = rid_q;
  assign hit_o          = hit_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_pathID_o  = resp_path_q;
  assign err_o          = err_q;
  assign grant_cnt_o    = cnt_q;

endmodule

// File: tb/tb_path_lookup_arbiter.sv
// tb/tb_path_lookup_arbiter.sv - self-checking bench for path_lookup_arbiter
module tb_path_lookup_arbiter;

  localparam int N   = 4;
  localparam int WR  = 16;
  localparam int WP  = 18;
  localparam int LAT = 3;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              arb_en_i;
  logic [N-1:0]      req_valid_i;
  logic [N*WR-1:0]   req_ruleID_i;
  logic [N-1:0]      req_hit_i;
  logic [N-1:0]      req_ready_o;
  logic              ruleID_valid_o;
  logic [WR-1:0]     ruleID_o;
  logic              hit_o;
  logic              pathID_valid_i;
  logic [WP-1:0]     pathID_i;
  logic [N-1:0]      resp_valid_o;
  logic [WP-1:0]     resp_pathID_o;
  logic [1:0]        err_o;
  logic [31:0]       grant_cnt_o;

  path_lookup_arbiter #(.N_REQ(N), .W_RULEID(WR), .W_PATHID(WP), .LAT(LAT)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .arb_en_i(arb_en_i),
    .req_valid_i(req_valid_i), .req_ruleID_i(req_ruleID_i), .req_hit_i(req_hit_i),
    .req_ready_o(req_ready_o), .ruleID_valid_o(ruleID_valid_o), .ruleID_o(ruleID_o),
    .hit_o(hit_o), .pathID_valid_i(pathID_valid_i), .pathID_i(pathID_i),
    .resp_valid_o(resp_valid_o), .resp_pathID_o(resp_pathID_o),
    .err_o(err_o), .grant_cnt_o(grant_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [WP-1:0] fpath(input logic [WR-1:0] r);
    if (r == 16'h0005) return 18'h01234;
    return {r[1:0], r ^ 16'h5A3C};
  endfunction

  // Fixed-latency lookup stage; it keeps running across DUT resets.
  logic [LAT-1:0] lk_v = '0;
  logic [WP-1:0]  lk_d [LAT];
  logic           lk_kill = 1'b0;
  logic           lk_inject = 1'b0;

  always @(posedge clk_i) begin
    lk_v    <= {lk_v[LAT-2:0], ruleID_valid_o};
    lk_d[0] <= fpath(ruleID_o);
    for (int k = 1; k < LAT; k++) lk_d[k] <= lk_d[k-1];
  end

  assign pathID_valid_i = (lk_v[LAT-1] & ~lk_kill) | lk_inject;
  assign pathID_i       = lk_inject ? 18'h2AAAA : lk_d[LAT-1];

  typedef struct {
    int           pc;
    int           idx;
    logic [WP-1:0] path;
  } pend_t;

  typedef struct {
    logic [N-1:0] rv;
    logic         en;
    logic [N-1:0] exp_rdy;
  } vec_t;

  pend_t         q[$];
  int            n_pass = 0;
  int            n_tot  = 0;
  int            cyc    = 0;
  int            m_last = N - 1;
  int            m_guard = 0;
  int            last_hs = -1;
  logic [31:0]   m_cnt = '0;
  logic          m_rv = 1'b0;
  logic [WR-1:0] m_rid = '0;
  logic          m_hit = 1'b0;
  logic [N-1:0]  m_resp = '0;
  logic [WP-1:0] m_path = '0;
  logic [1:0]    m_err = '0;
  logic [N-1:0]  last_rdy = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: check grant before the edge, update the reference, check registered outputs after.
  task automatic cycle_step();
    int            w;
    logic [N-1:0]  er;
    logic [WR-1:0] r;
    logic          h;
    logic          pv, tapv;
    logic [N-1:0]  nresp;
    logic [WP-1:0] npath;
    logic [1:0]    nerr;
    #1;
    w = -1;
    if (arb_en_i && !reset_i)
      for (int k = 1; k <= N; k++)
        if (w < 0 && req_valid_i[(m_last + k) % N]) w = (m_last + k) % N;
    er = '0;
    r  = '0;
    h  = 1'b0;
    if (w >= 0) begin
      er[w] = 1'b1;
      r = req_ruleID_i[w*WR +: WR];
      h = req_hit_i[w];
    end
    last_rdy = req_ready_o;
    chk("req_ready", 64'(req_ready_o), 64'(er));
    pv    = pathID_valid_i;
    tapv  = (q.size() > 0) && (q[0].pc == cyc);
    nresp = '0;
    npath = m_path;
    nerr  = m_err;
    if (tapv) begin
      if (pv) begin
        nresp[q[0].idx] = 1'b1;
        npath = q[0].path;
      end
      void'(q.pop_front());
    end
    if (m_guard == 0) begin
      if (pv && !tapv) nerr[0] = 1'b1;
      if (tapv && !pv) nerr[1] = 1'b1;
    end
    @(posedge clk_i);
    cyc++;
    if (reset_i) begin
      m_last = N - 1; m_cnt = '0; m_rv = 1'b0; m_rid = '0; m_hit = 1'b0;
      m_resp = '0; m_path = '0; m_err = '0; m_guard = LAT + 1;
      q.delete();
    end else begin
      m_resp = nresp; m_path = npath; m_err = nerr;
      if (m_guard > 0) m_guard--;
      m_rv = (w >= 0);
      if (w >= 0) begin
        m_last = w; m_cnt++; m_rid = r; m_hit = h;
        q.push_back('{pc: cyc + LAT, idx: w, path: fpath(r)});
      end
    end
    #1;
    chk("ruleID_valid", 64'(ruleID_valid_o), 64'(m_rv));
    chk("ruleID", 64'(ruleID_o), 64'(m_rid));
    chk("hit", 64'(hit_o), 64'(m_hit));
    chk("resp_valid", 64'(resp_valid_o), 64'(m_resp));
    chk("resp_pathID", 64'(resp_pathID_o), 64'(m_path));
    chk("err", 64'(err_o), 64'(m_err));
    chk("grant_cnt", 64'(grant_cnt_o), 64'(m_cnt));
    @(negedge clk_i);
    last_hs = w;
    if (w >= 0) begin
      req_ruleID_i[w*WR +: WR] = WR'($urandom);
      req_hit_i[w] = 1'($urandom);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) cycle_step();
  endtask

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{4'b1111, 1'b1, 4'b0001};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0010};
    tbl[2]  = '{4'b1111, 1'b1, 4'b0100};
    tbl[3]  = '{4'b1010, 1'b1, 4'b1000};
    tbl[4]  = '{4'b1010, 1'b1, 4'b0010};
    tbl[5]  = '{4'b1010, 1'b0, 4'b0000};
    tbl[6]  = '{4'b0001, 1'b1, 4'b0001};
    tbl[7]  = '{4'b0000, 1'b1, 4'b0000};
    tbl[8]  = '{4'b0110, 1'b1, 4'b0010};
    tbl[9]  = '{4'b0110, 1'b1, 4'b0100};
    tbl[10] = '{4'b0110, 1'b1, 4'b0010};
    tbl[11] = '{4'b1000, 1'b1, 4'b1000};

    reset_i = 1'b1; arb_en_i = 1'b1; req_valid_i = '0; req_hit_i = '0;
    for (int i = 0; i < N; i++) req_ruleID_i[i*WR +: WR] = WR'($urandom);

    // Reset state
    steps(2);
    chk("rst_grant_cnt", 64'(grant_cnt_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    reset_i = 1'b0;

    // Single request on requester 2
    req_valid_i = 4'b0100; req_ruleID_i[2*WR +: WR] = 16'h0005; req_hit_i[2] = 1'b1;
    cycle_step();
    req_valid_i = '0;
    chk("t1_ready", 64'(last_rdy), 64'h4);
    chk("t1_ruleID_valid", 64'(ruleID_valid_o), 64'd1);
    chk("t1_ruleID", 64'(ruleID_o), 64'h0005);
    steps(LAT);
    chk("t1_resp_early", 64'(resp_valid_o), 64'd0);
    cycle_step();
    chk("t1_resp_valid", 64'(resp_valid_o), 64'h4);
    chk("t1_resp_pathID", 64'(resp_pathID_o), 64'h1234);
    chk("t1_grant_cnt", 64'(grant_cnt_o), 64'd1);
    steps(2);

    // Table vectors from a fresh reset
    reset_i = 1'b1; cycle_step(); reset_i = 1'b0;
    for (int v = 0; v < 12; v++) begin
      req_valid_i = tbl[v].rv; arb_en_i = tbl[v].en;
      cycle_step();
      chk($sformatf("tbl%0d_ready", v), 64'(last_rdy), 64'(tbl[v].exp_rdy));
    end
    req_valid_i = '0; arb_en_i = 1'b1;
    steps(6);

    // Fairness: all valid for 12 cycles
    reset_i = 1'b1; cycle_step(); reset_i = 1'b0;
    req_valid_i = 4'b1111;
    for (int k = 0; k < 12; k++) begin
      cycle_step();
      chk($sformatf("fair%0d", k), 64'(last_rdy), 64'(1 << (k % 4)));
    end
    chk("fair_grant_cnt", 64'(grant_cnt_o), 64'd12);
    req_valid_i = '0;
    steps(6);

    // Requesters 1 and 3, requester 1 drops after its grant
    req_valid_i = 4'b1010;
    cycle_step();
    chk("mix_first", 64'(last_rdy), 64'h2);
    req_valid_i = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      cycle_step();
      chk("mix_rest", 64'(last_rdy), 64'h8);
    end
    req_valid_i = '0;
    steps(6);

    // arb_en toggle with three lookups in flight
    req_valid_i = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      cycle_step();
      chk("en_pre", 64'(last_rdy), 64'(1 << k));
    end
    arb_en_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle_step();
      chk("en_off", 64'(last_rdy), 64'd0);
    end
    arb_en_i = 1'b1;
    cycle_step();
    chk("en_resume", 64'(last_rdy), 64'h8);
    req_valid_i = '0;
    steps(6);

    // Orphan response, then a dropped response
    lk_inject = 1'b1; cycle_step(); lk_inject = 1'b0;
    chk("err_orphan", 64'(err_o), 64'h1);
    req_valid_i = 4'b0001;
    cycle_step();
    chk("err_grant", 64'(last_rdy), 64'h1);
    req_valid_i = '0;
    steps(LAT);
    lk_kill = 1'b1; cycle_step(); lk_kill = 1'b0;
    chk("err_lost", 64'(err_o), 64'h3);
    steps(4);
    chk("err_sticky", 64'(err_o), 64'h3);

    // Reset with two lookups in flight
    req_valid_i = 4'b0011;
    cycle_step();
    chk("rmf_g0", 64'(last_rdy), 64'h2);
    cycle_step();
    chk("rmf_g1", 64'(last_rdy), 64'h1);
    req_valid_i = '0;
    steps(2);
    reset_i = 1'b1; cycle_step(); reset_i = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      cycle_step();
      chk("rmf_no_resp", 64'(resp_valid_o), 64'd0);
    end
    chk("rmf_err", 64'(err_o), 64'd0);
    chk("rmf_grant_cnt", 64'(grant_cnt_o), 64'd0);
    req_valid_i = 4'b1111;
    cycle_step();
    chk("rmf_first", 64'(last_rdy), 64'h1);
    req_valid_i = '0;
    steps(6);

    // Randomized traffic against the reference model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid_i[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            req_valid_i[i] = 1'b1;
            req_ruleID_i[i*WR +: WR] = WR'($urandom);
            req_hit_i[i] = 1'($urandom);
          end
        end else if ($urandom_range(0, 7) == 0) begin
          req_valid_i[i] = 1'b0;
        end
      end
      arb_en_i = ($urandom_range(0, 7) != 0);
      cycle_step();
      if (last_hs >= 0 && $urandom_range(0, 1) == 1) req_valid_i[last_hs] = 1'b0;
    end
    req_valid_i = '0; arb_en_i = 1'b1;
    steps(8);
    chk("final_err", 64'(err_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
